// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types and constants for the die roll generator
//
// Contents:
//   roll_state_t  : roll FSM states (IDLE, REQ, WAIT, CHECK, DONE)
//   DEFAULT_SIDES : default number of die faces
//   REJECT_MAX    : saturation value of the rejection counter
//   draw_width    : bits drawn per attempt for a given number of faces

package dice_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } roll_state_t;

    localparam int DEFAULT_SIDES = 6;

    localparam logic [7:0] REJECT_MAX = 8'd255;

    // At least one bit per attempt, even for a two-faced die.
    function automatic int draw_width(input int sides);
        return (sides > 2) ? $clog2(sides) : 1;
    endfunction

endpackage

// File: rtl/die_bit_shifter.sv
// rtl/die_bit_shifter.sv - MSB-first serial collector for one draw attempt
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : zero the collected bits and the bit counter
//   shift_en   : shift serial_in into the LSB and count one bit
//   serial_in  : incoming random bit
//   value      : bits collected so far, first bit ends up in the MSB
//   full       : WIDTH bits have been collected
//   last       : exactly WIDTH-1 bits collected; the next shift completes the draw

module die_bit_shifter
    import dice_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] value,
    output logic             full,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] bit_cnt;

    assign full = (bit_cnt == CW'(WIDTH));
    assign last = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            value   <= '0;
            bit_cnt <= '0;
        end else if (shift_en && !full) begin
            // Casting the concatenation drops the old MSB; this also covers WIDTH == 1.
            value   <= WIDTH'({value, serial_in});
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/die_roll_gen.sv
// rtl/die_roll_gen.sv - uniform die face generator fed by a serial RNG
//
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   roll_req     : request a roll, sampled only while idle
//   rng_start    : one-cycle request pulse to the RNG
//   rng_bit      : RNG result bit, meaningful while rng_done is high
//   rng_done     : RNG completion pulse
//   busy         : high whenever a roll is in progress
//   roll_valid   : one-cycle pulse when roll_value has been updated
//   roll_value   : accepted face 1..SIDES, held between rolls
//   reject_cnt   : out-of-range attempts in the current/last roll, saturating

module die_roll_gen
    import dice_pkg::*;
#(
    parameter int SIDES = DEFAULT_SIDES,
    parameter int WIDTH = draw_width(SIDES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_req,
    output logic       rng_start,
    input  logic       rng_bit,
    input  logic       rng_done,
    output logic       busy,
    output logic       roll_valid,
    output logic [7:0] roll_value,
    output logic [7:0] reject_cnt
);

    roll_state_t      state;
    logic [WIDTH-1:0] draw;
    logic             draw_full;
    logic             draw_last;
    logic             shift_en;
    logic             clear;
    logic             accept;

    // A bit is only captured while waiting for it; stray done pulses elsewhere are dropped.
    assign shift_en = (state == WAIT) && rng_done;

    // Compare in 9 bits so SIDES up to 255 never truncates.
    assign accept = draw_full && (9'(draw) < 9'(SIDES));

    // New roll, or a rejected attempt that must be redrawn from scratch.
    assign clear = ((state == IDLE) && roll_req) || ((state == CHECK) && !accept);

    assign busy = (state != IDLE);

    die_bit_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (shift_en),
        .serial_in(rng_bit),
        .value    (draw),
        .full     (draw_full),
        .last     (draw_last)
    );

    // rng_start and roll_valid are set on the edge entering REQ/DONE so each is
    // high for exactly the one cycle spent in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rng_start  <= 1'b0;
            roll_valid <= 1'b0;
            roll_value <= 8'd0;
            reject_cnt <= 8'd0;
        end else begin
            rng_start  <= 1'b0;
            roll_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (roll_req) begin
                        reject_cnt <= 8'd0;
                        rng_start  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (rng_done) begin
                        if (draw_last) begin
                            state <= CHECK;
                        end else begin
                            rng_start <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        roll_value <= 8'(draw) + 8'd1;
                        roll_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (reject_cnt != REJECT_MAX) begin
                            reject_cnt <= reject_cnt + 8'd1;
                        end
                        rng_start <= 1'b1;
                        state     <= REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/die_roll_gen.md
# die_roll_gen

Converts the serial output of the RNG bit generator into a uniformly distributed die face 1..SIDES. It sits directly downstream of `RNG`. On each roll request it pulses the RNG's `start` and collects one `result` bit per `done`. It then assembles WIDTH bits MSB-first and applies rejection sampling, so values ≥ SIDES are discarded and re-drawn. The accepted face goes to the display/score logic through a one-cycle valid pulse.

## Interface
- SIDES, 6, number of die faces; legal range 2..255
- WIDTH, max(1, $clog2(SIDES)), bits drawn per attempt; derived, do not override
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- roll_req  in  1  request a roll; sampled only in IDLE
- rng_start  out  1  one-cycle pulse to RNG `start`
- rng_bit  in  1  RNG `result`, valid only while rng_done=1
- rng_done  in  1  RNG `done`; one-cycle pulse, ≥1 cycle after rng_start
- busy  out  1  high in every state except IDLE
- roll_valid  out  1  one-cycle pulse, roll_value updated this cycle
- roll_value  out  8  accepted face, 1..SIDES; held until next accepted roll
- reject_cnt  out  8  rejected attempts in the current/last roll, saturating at 255

## Operation
- FSM states: IDLE, REQ, WAIT, CHECK, DONE.
- IDLE → REQ when roll_req=1. This clears shift_reg, bit_cnt and reject_cnt.
- REQ: rng_start=1 for exactly this cycle, then WAIT.
- WAIT: hold until rng_done=1. On that edge:
  - shift_reg ← {shift_reg[WIDTH-2:0], rng_bit}; bit_cnt++.
  - Go to CHECK if bit_cnt reaches WIDTH, else go to REQ.
- CHECK, shift_reg < SIDES (accept): roll_value ← shift_reg + 1, zero-extended to 8 bits; go to DONE.
- CHECK, otherwise (reject): reject_cnt ← min(reject_cnt+1, 255); bit_cnt ← 0; go to REQ.
- DONE: roll_valid=1 for one cycle, then IDLE.
- roll_req outside IDLE is ignored; it is not queued.
- rng_done outside WAIT is ignored and no bit is captured.
- rng_done coinciding with reset: reset wins.
- Power-of-two SIDES never rejects.
- No retry limit; the roll completes when the RNG eventually produces an in-range value.
- Async reset at any point, including mid-roll:
  - state=IDLE; rng_start=0, busy=0, roll_valid=0, roll_value=0, reject_cnt=0, shift_reg=0, bit_cnt=0.
  - The interrupted roll is discarded and produces no roll_valid.

## Timing
- All outputs are registered, except busy, which is decoded from the state register.
- Cycle numbering: the edge sampling roll_req ends cycle 0.
- Zero-wait RNG (rng_done in the cycle after rng_start), no rejection:
  - rng_start high in cycles 1, 3, …, 2·WIDTH−1.
  - CHECK in cycle 2·WIDTH+1; roll_valid in cycle 2·WIDTH+2.
  - SIDES=6 gives roll_valid in cycle 8.
- Each rejection adds 2·WIDTH+1 cycles.
- Each cycle of RNG latency beyond one adds one cycle per bit.
- Back-to-back rolls: roll_req may be sampled in the cycle after DONE, so the minimum roll period is 2·WIDTH+3 cycles.
- Reset reaches the outputs asynchronously. Release is synchronous to clk, and the first roll_req is sampled on the first edge after deassertion.

## Structure
- Shared package `dice_pkg`:
  - state enum `roll_state_t` {IDLE, REQ, WAIT, CHECK, DONE}.
  - `DEFAULT_SIDES = 6`.
  - `REJECT_MAX = 8'd255`.
- One sub-module, `die_bit_shifter`, contains shift_reg and bit_cnt. Its controls are clear, shift-enable and serial-in; its outputs are value and full (bit_cnt==WIDTH).
- The FSM, accept/reject compare and output registers live in the top level.
- The bench pairs the block with a behavioural RNG model that returns scripted bits with programmable done latency.

## Test plan
- Reset values: assert reset mid-WAIT (after 2 bits) → all outputs 0, state IDLE immediately; no roll_valid afterwards; a new roll_req completes normally.
- SIDES=6, bits 0,0,0 with zero-wait RNG → roll_valid in cycle 8, roll_value=1, reject_cnt=0. Bits 1,0,1 → roll_value=6.
- SIDES=6, bits 1,1,0 (rejected), then 0,1,1 → one rejection, roll_value=4, reject_cnt=1, roll_valid in cycle 15.
- SIDES=6, RNG scripted to give 1,1,1 for 300 attempts, then 0,1,0 → reject_cnt saturates at 255, roll_value=3.
- roll_req held high while busy, and spurious rng_done pulses in IDLE/REQ → exactly one roll per IDLE sample; no extra bits captured (checked via roll_value). Back-to-back rolls are 9 cycles apart.
- SIDES=8, 1000 random rolls with random RNG latency 1–5 → reject_cnt always 0; roll_value always in 1..8; every roll_value equals the scripted bits+1.
